// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator: decodes I/S/B/U/J from opcode, sign-extends to XLEN, carries a tag.
// Latency: 1 cycle from accept to out_* when empty; 1 result/cycle sustained while out_ready=1.
// Backpressure: 2-entry FIFO; in_ready (registered) drops when full, flush/rst empty the buffer.
//
// Ports:
//   clk, rst (sync, active-high), flush (sync discard of buffered entries)
//   in_valid/in_ready/ins/in_tag        : instruction in, valid-ready handshake
//   out_valid/out_ready                 : result out, valid-ready handshake
//   out_imm/out_fmt/out_illegal/out_tag : head entry, forced to 0 when !out_valid
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ins,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  // ---------------- decode (write path) ----------------
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  always_comb begin
    dec_imm32 = 32'd0;
    dec_fmt   = FMT_NONE;
    dec_ill   = 1'b0;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_imm32 = {{20{ins[31]}}, ins[31:20]};
        dec_fmt   = FMT_I;
      end
      7'b0100011: begin
        dec_imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        dec_fmt   = FMT_S;
      end
      7'b1100011: begin
        dec_imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        dec_fmt   = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm32 = {ins[31:12], 12'd0};
        dec_fmt   = FMT_U;
      end
      7'b1101111: begin
        dec_imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        dec_fmt   = FMT_J;
      end
      default: dec_ill = 1'b1;
    endcase
    // Every format's top immediate bit is ins[31]; widen by replicating it.
    dec_imm       = {XLEN{dec_imm32[31]}};
    dec_imm[31:0] = dec_imm32;
  end

  // ---------------- 2-entry FIFO ----------------
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  in_ready_q, in_ready_d;
  logic [1:0][XLEN-1:0]  imm_q, imm_d;
  logic [1:0][2:0]       fmt_q, fmt_d;
  logic [1:0]            ill_q, ill_d;
  logic [1:0][TAG_W-1:0] tag_q, tag_d;
  logic                  wr_en, rd_en;

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = in_ready_q;

  // flush wins over both handshakes: nothing is written or consumed that cycle.
  assign wr_en = in_valid & in_ready_q & ~flush;
  assign rd_en = out_valid & out_ready & ~flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = ~wr_ptr_q;
      if (rd_en) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, wr_en} - {1'b0, rd_en};
    end
    // Registered ready reflects occupancy after this edge, so it never
    // advertises space that a same-cycle read has not yet freed when full.
    in_ready_d = (count_d != 2'd2);
  end

  always_comb begin
    imm_d = imm_q;
    fmt_d = fmt_q;
    ill_d = ill_q;
    tag_d = tag_q;
    if (wr_en) begin
      imm_d[wr_ptr_q] = dec_imm;
      fmt_d[wr_ptr_q] = dec_fmt;
      ill_d[wr_ptr_q] = dec_ill;
      tag_d[wr_ptr_q] = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Payload storage is only observed through count, so it carries no reset.
  always_ff @(posedge clk) begin
    imm_q <= imm_d;
    fmt_q <= fmt_d;
    ill_q <= ill_d;
    tag_q <= tag_d;
  end

  assign out_imm     = out_valid ? imm_q[rd_ptr_q] : '0;
  assign out_fmt     = out_valid ? fmt_q[rd_ptr_q] : FMT_NONE;
  assign out_illegal = out_valid ? ill_q[rd_ptr_q] : 1'b0;
  assign out_tag     = out_valid ? tag_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
// Table vectors for decode/latency, hand sequences for backpressure/flush/reset,
// then a random valid/ready run checked against a queue scoreboard.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] ins, in_tag;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_tag;
  logic [2:0]  out_fmt;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic [2:0]  out_fmt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .ins(ins), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .ins(ins), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64));

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  // Reference immediate decode, written straight from the field layouts.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] tag);
    exp_t        e;
    logic [31:0] v;
    v = 32'd0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    e.tag = tag;
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin v = {{20{w[31]}}, w[31:20]}; e.fmt = 3'd1; end
      7'h23: begin v = {{20{w[31]}}, w[31:25], w[11:7]}; e.fmt = 3'd2; end
      7'h63: begin v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; e.fmt = 3'd3; end
      7'h37, 7'h17: begin v = {w[31:12], 12'h000}; e.fmt = 3'd4; end
      7'h6F: begin v = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; e.fmt = 3'd5; end
      default: e.ill = 1'b1;
    endcase
    e.imm = {{32{v[31]}}, v};
    return e;
  endfunction

  // Scoreboard monitor: samples mid-cycle, i.e. what the next rising edge will do.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 || flush === 1'b1) begin
      sb.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_output", 64'(out_tag), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("sb_imm32", 64'(out_imm), {32'd0, e.imm[31:0]});
          chk("sb_imm64", out_imm64, e.imm);
          chk("sb_fmt", 64'(out_fmt), 64'(e.fmt));
          chk("sb_ill", 64'(out_illegal), 64'(e.ill));
          chk("sb_tag", 64'(out_tag), 64'(e.tag));
          chk("sb_valid64", 64'(out_valid64), 64'd1);
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(model(ins, in_tag));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_out(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_imm"}, 64'(out_imm), 64'd0);
    chk({tag, "_imm64"}, out_imm64, 64'd0);
    chk({tag, "_fmt"}, 64'(out_fmt), 64'd0);
    chk({tag, "_ill"}, 64'(out_illegal), 64'd0);
    chk({tag, "_tag"}, 64'(out_tag), 64'd0);
  endtask

  initial begin
    logic [6:0]  ops[11];
    logic [31:0] r;
    logic [31:0] tag_ctr;

    vecs[0]  = '{32'h00410113, 64'h0000000000000004, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    vecs[2]  = '{32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};
    vecs[3]  = '{32'h123450B7, 64'h0000000012345000, 3'd4, 1'b0};
    vecs[4]  = '{32'h001000EF, 64'h0000000000000800, 3'd5, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[6]  = '{32'hFFF02083, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[7]  = '{32'h00001097, 64'h0000000000001000, 3'd4, 1'b0};
    vecs[8]  = '{32'h000080E7, 64'h0000000000000000, 3'd1, 1'b0};
    vecs[9]  = '{32'h00208463, 64'h0000000000000008, 3'd3, 1'b0};
    vecs[10] = '{32'h0000000F, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[11] = '{32'h80000037, 64'hFFFFFFFF80000000, 3'd4, 1'b0};

    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ins = 32'd0; in_tag = 32'd0;

    // Reset state
    tick();
    tick();
    chk_zero_out("rst");
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_in_ready64", 64'(in_ready64), 64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    // Decode table: one entry at a time, result must appear the next cycle.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      ins      = vecs[i].ins;
      in_tag   = 32'h1000 + 32'(i);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_imm32", i), 64'(out_imm), {32'd0, vecs[i].imm[31:0]});
      chk($sformatf("vec%0d_imm64", i), out_imm64, vecs[i].imm);
      chk($sformatf("vec%0d_fmt", i), 64'(out_fmt), 64'(vecs[i].fmt));
      chk($sformatf("vec%0d_ill", i), 64'(out_illegal), 64'(vecs[i].ill));
      chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'h1000 + 64'(i));
      tick();
      chk($sformatf("vec%0d_drained", i), 64'(out_valid), 64'd0);
    end

    // Backpressure: three pushes against a stalled consumer.
    out_ready = 1'b0;
    ins = 32'h00410113;
    in_valid = 1'b1; in_tag = 32'h100;
    tick();
    chk("bp_ready_after1", 64'(in_ready), 64'd1);
    in_tag = 32'h104;
    tick();
    chk("bp_ready_after2", 64'(in_ready), 64'd0);
    in_tag = 32'h108;
    tick();
    chk("bp_head_stable", 64'(out_tag), 64'h100);
    chk("bp_still_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_second", 64'(out_tag), 64'h104);
    chk("bp_ready_release", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_third", 64'(out_tag), 64'h108);
    chk("bp_third_valid", 64'(out_valid), 64'd1);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush while full with a pending write.
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 32'h200;
    tick();
    in_tag = 32'h204;
    tick();
    in_tag = 32'h208; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_valid", 64'(out_valid), 64'd0);
    chk("flush_full_ready", 64'(in_ready), 64'd1);
    // Flush with one entry while a write is being accepted: that write is lost too.
    in_valid = 1'b1; in_tag = 32'h20C;
    tick();
    in_tag = 32'h210; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_wr_valid", 64'(out_valid), 64'd0);
    tick();
    chk("flush_wr_stays_empty", 64'(out_valid), 64'd0);

    // Random valid/ready with occasional flush and one mid-run reset.
    tag_ctr = 32'h4000;
    for (int c = 0; c < 10000; c++) begin
      if (c == 5001) begin
        chk_zero_out("midrst");
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
      end
      rst       = (c == 5000);
      flush     = ($urandom_range(0, 63) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      r         = $urandom;
      ins       = {r[31:7], ops[$urandom_range(0, 10)]};
      if ($urandom_range(0, 15) == 0) ins = $urandom;
      in_tag    = tag_ctr;
      tag_ctr   = tag_ctr + 32'd4;
      tick();
    end

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("final_drain", 64'(sb.size()), 64'd0);
    chk("final_idle", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
